// File: rtl/barrett_pkg.sv
// -----------------------------------------------------------------------------
// barrett_pkg
// Shared definitions for the Barrett parameter generator and the downstream
// Barrett reducer: default modulus / result widths and the generator FSM
// state encoding.
// -----------------------------------------------------------------------------
package barrett_pkg;

  localparam int Q_W  = 64;       // modulus width
  localparam int MU_W = Q_W + 2;  // mu = floor(2^(2k)/q) needs up to Q_W+2 bits
  localparam int K_W  = 8;        // bit length of q, 0..Q_W

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/clz_q.sv
// -----------------------------------------------------------------------------
// clz_q
// Combinational leading-zero count over a W-bit operand.
// Ports:
//   a   : operand
//   clz : number of leading zeros; equals W when a is zero
// -----------------------------------------------------------------------------
module clz_q #(
  parameter int W    = 64,
  parameter int CW   = $clog2(W + 1)
) (
  input  logic [W-1:0]  a,
  output logic [CW-1:0] clz
);

  // Scan from LSB upward so the highest set bit is the last one to write.
  always_comb begin
    clz = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (a[i]) clz = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/barrett_param_gen.sv
// -----------------------------------------------------------------------------
// barrett_param_gen
// Computes the parameters for a Barrett reducer from a modulus q:
//   k  = bit length of q
//   mu = floor(2^(2k) / q), via a bit-serial restoring division
// Sequence: accept -> NORM (one cycle, computes k) -> DIV (2k+1 cycles) -> DONE.
// valid rises on the (2k+3)-th rising edge counting the accept edge as the
// first; for q = 0 it rises on the second edge with err=1, k=0, mu all-ones.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start, q   : request and modulus, sampled when ready=1
//   clr        : synchronous abort, wins over start
//   ready      : high in IDLE and DONE
//   valid, err : results valid / q was zero
//   k, mu      : results, held in DONE until the next accepted start
//   rem        : 2^(2k) mod q (only with BARRETT_PARAM_REM_EN defined)
//
// Build option: define BARRETT_PARAM_REM_EN to add the rem output.
// -----------------------------------------------------------------------------
module barrett_param_gen #(
  parameter int Q_W  = barrett_pkg::Q_W,
  parameter int MU_W = Q_W + 2,
  parameter int K_W  = barrett_pkg::K_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [Q_W-1:0]  q,
  input  logic            clr,
  output logic            ready,
  output logic            valid,
  output logic            err,
  output logic [K_W-1:0]  k,
  output logic [MU_W-1:0] mu
`ifdef BARRETT_PARAM_REM_EN
  ,
  output logic [Q_W-1:0]  rem
`endif
);

  import barrett_pkg::*;

  localparam int CLZ_W = $clog2(Q_W + 1);
  localparam int CNT_W = K_W + 1;   // counts up to 2k

  state_e           state_q, state_d;
  logic [Q_W-1:0]   q_q, q_d;
  logic [Q_W:0]     r_q, r_d;       // working remainder, always < q between steps
  logic [MU_W-1:0]  mu_q, mu_d;     // doubles as the quotient shift register
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [K_W-1:0]   k_q, k_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             arm_q, arm_d;   // low for the first edge after reset release

  logic [CLZ_W-1:0] clz;
  logic [K_W-1:0]   k_norm;
  logic             dbit;
  logic [Q_W+1:0]   r_sh;
  logic             ge;
  logic             last;
  logic             accept;

  clz_q #(
    .W (Q_W)
  ) u_clz (
    .a   (q_q),
    .clz (clz)
  );

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    mu_d    = mu_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    valid_d = valid_q;
    err_d   = err_q;
    arm_d   = 1'b1;

    k_norm  = K_W'(Q_W) - K_W'(clz);
    // Dividend 2^(2k) is a single 1 followed by 2k zeros, MSB first.
    dbit    = (cnt_q == '0);
    r_sh    = {r_q, dbit};
    ge      = (r_sh >= (Q_W + 2)'(q_q));
    last    = (cnt_q == {k_q, 1'b0});
    accept  = start && arm_q && ((state_q == IDLE) || (state_q == DONE));

    unique case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          q_d     = q;
          r_d     = '0;
          mu_d    = '0;
          valid_d = 1'b0;
          err_d   = 1'b0;
          state_d = NORM;
        end
      end
      NORM: begin
        k_d   = k_norm;
        cnt_d = '0;
        if (q_q == '0) begin
          err_d   = 1'b1;
          k_d     = '0;
          mu_d    = '1;
          r_d     = '0;
          valid_d = 1'b1;
          state_d = DONE;
        end else begin
          state_d = DIV;
        end
      end
      DIV: begin
        // After a conditional subtract the value is below q, so the
        // truncation to Q_W+1 bits loses nothing.
        r_d   = ge ? (Q_W + 1)'(r_sh - (Q_W + 2)'(q_q)) : r_sh[Q_W:0];
        mu_d  = {mu_q[MU_W-2:0], ge};
        cnt_d = cnt_q + CNT_W'(1);
        if (last) begin
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (clr) begin
      state_d = IDLE;
      r_d     = '0;
      mu_d    = '0;
      k_d     = '0;
      valid_d = 1'b0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      mu_q    <= '0;
      k_q     <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      mu_q    <= mu_d;
      k_q     <= k_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      arm_q   <= arm_d;
    end
  end

  // Pure datapath: only read after being loaded in the accept / NORM cycles.
  always_ff @(posedge clk) begin
    q_q   <= q_d;
    cnt_q <= cnt_d;
  end

  assign ready = (state_q == IDLE) || (state_q == DONE);
  assign valid = valid_q;
  assign err   = err_q;
  assign k     = k_q;
  assign mu    = mu_q;
`ifdef BARRETT_PARAM_REM_EN
  assign rem   = r_q[Q_W-1:0];
`endif

endmodule

// File: doc/barrett_param_gen.md
BARRETT_PARAM_GEN -- requirements
Module: barrett_param_gen

Interface
REQ-001 SHALL have parameter Q_W, default 64: modulus width.
REQ-002 SHALL have parameter MU_W, default Q_W+2: width of the mu result.
REQ-003 SHALL have parameter K_W, default 8: width of the k result.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1 bit: request, sampled only while ready=1.
REQ-007 SHALL have port q, input, Q_W bits: modulus, captured on the accept edge.
REQ-008 SHALL have port clr, input, 1 bit: synchronous abort.
REQ-009 SHALL have port ready, output, 1 bit: high in IDLE and DONE.
REQ-010 SHALL have port valid, output, 1 bit: results are valid.
REQ-011 SHALL have port err, output, 1 bit: q was 0.
REQ-012 SHALL have port k, output, K_W bits: bit length of q.
REQ-013 SHALL have port mu, output, MU_W bits: floor(2^(2k)/q).

Function
REQ-014 SHALL generate parameters for the downstream Barrett reducer: k = position of the highest set bit of q plus 1, and mu = floor(2^(2k)/q).
REQ-015 SHALL implement states IDLE, NORM, DIV and DONE.
REQ-016 SHALL accept a request when start=1 and ready=1; it SHALL then capture q, clear valid and err, and go to NORM.
REQ-017 SHALL, in NORM, compute k in one cycle; if q=0 it SHALL set err=1, k=0, mu all-ones and go to DONE; otherwise it SHALL go to DIV.
REQ-018 SHALL, in DIV, run a restoring division of 2^(2k) by q, one quotient bit per cycle, over exactly 2k+1 cycles.
  - Per step: r = (r<<1) | dividend bit; if r >= q then r -= q and the quotient bit is 1.
  - Remainder r SHALL be Q_W+1 bits wide.
REQ-019 SHALL set latency from the accept edge to valid=1 at exactly 2k+3 cycles; for q=0 it SHALL be 2 cycles.
REQ-020 SHALL hold valid, err, k and mu stable in DONE until the next accepted start.
REQ-021 SHALL ignore start while busy (NORM or DIV); ready=0 there.
REQ-022 SHALL, on clr=1 in any state, go to IDLE next cycle, zero all outputs and set ready=1; clr SHALL win over a simultaneous start.
REQ-023 SHALL cover the extremes: q=1 gives k=1 and mu=4; q=2^(Q_W-1) gives mu=2^(Q_W+1); q=2^Q_W-1 gives mu=2^Q_W+1. No overflow in any case.

Reset
REQ-024 SHALL, while rst_n=0, force state IDLE with ready=1, valid=0, err=0, k=0 and mu=0, regardless of clk.
REQ-025 SHALL discard any operation in progress when reset is asserted mid-division; no stale result appears after release.
REQ-026 SHALL not accept start in the cycle in which rst_n is released.

Configuration
REQ-027 SHALL, with BARRETT_PARAM_REM_EN defined, add output rem (Q_W bits) = 2^(2k) mod q, valid with valid; for q=0, rem=0.
REQ-028 SHALL, without BARRETT_PARAM_REM_EN, have no rem port and no logic for it; all other behaviour is identical.

Structure
REQ-029 SHALL place Q_W, MU_W, K_W and the state enum in the shared package barrett_pkg; the reducer uses the same package.
REQ-030 SHALL instantiate exactly one sub-module, clz_q (combinational leading-zero count over Q_W bits); k = Q_W - clz.
REQ-031 SHALL use one datapath (remainder register, quotient shift register, bit counter) and one FSM; no multipliers.

Verification
REQ-032 SHALL cover: q=7 -> k=3, mu=9, valid exactly 9 cycles after accept (rem=1 if enabled).
REQ-033 SHALL cover: q=0 -> err=1, k=0, mu all-ones, valid 2 cycles after accept.
REQ-034 SHALL cover: q=2^63 -> k=64, mu=2^65; q=2^64-1 -> k=64, mu=2^64+1; latency 131 cycles.
REQ-035 SHALL cover: start pulsed during DIV for q=7 -> ignored; the first result is unchanged (mu=9).
REQ-036 SHALL cover: clr, or rst_n low, at DIV cycle 5 for q=1000 -> ready=1, valid=0 and mu=0 next cycle; a fresh q=1000 then gives k=10, mu=1048.
REQ-037 SHALL cover: randomized q values, with mu checked against floor(2^(2k)/q) from a reference model, and mu fed into the reducer to confirm the reduced result is less than q.
